// File: rtl/button_led_sequencer.sv
// Mode controller for the 5-button / 5-LED path: synchronise, debounce, then drive the LEDs
// as a mirror, a per-button toggle latch or a running-light chase.
module button_led_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CHASE_DIV       = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sw,
    input  logic       mode_btn,
    output logic [4:0] led,
    output logic [1:0] mode
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW = (CHASE_DIV > 1) ? $clog2(CHASE_DIV) : 1;
    localparam logic [CW-1:0] DebLast = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PreLast = PW'(CHASE_DIV - 1);

    typedef enum logic [1:0] {
        StMirror = 2'd0,
        StToggle = 2'd1,
        StChase  = 2'd2
    } mode_e;

    // Bit 5 carries the mode button, bits 4:0 the switches.
    logic [5:0]    sync1_q, sync2_q;
    logic [5:0]    deb_q, deb_d, deb_prev_q;
    logic [CW-1:0] cnt_q [6];
    logic [CW-1:0] cnt_d [6];
    logic [5:0]    rise;
    logic          mode_rise;
    logic [4:0]    sw_rise;

    mode_e         state_q, state_d;
    logic          enter_toggle, enter_chase;
    logic [4:0]    latch_q, latch_d;
    logic [4:0]    pattern_q, pattern_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    led_q, led_d;

    assign rise      = deb_q & ~deb_prev_q;
    assign mode_rise = rise[5];
    assign sw_rise   = rise[4:0];

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 6; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DebLast) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StMirror;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StMirror: if (mode_rise) state_d = StToggle;
            StToggle: if (mode_rise) state_d = StChase;
            StChase:  if (mode_rise) state_d = StMirror;
            default:  state_d = StMirror;
        endcase

        enter_toggle = (state_d == StToggle) && (state_q != StToggle);
        enter_chase  = (state_d == StChase) && (state_q != StChase);

        // A coincident mode change takes priority over any switch pulse.
        latch_d = latch_q;
        if (enter_toggle) begin
            latch_d = '0;
        end else if ((state_q == StToggle) && !mode_rise) begin
            latch_d = latch_q ^ sw_rise;
        end

        pattern_d = pattern_q;
        presc_d   = presc_q;
        if (enter_chase) begin
            pattern_d = 5'b00001;
            presc_d   = '0;
        end else if ((state_q == StChase) && !deb_q[0]) begin
            if (presc_q == PreLast) begin
                presc_d   = '0;
                pattern_d = deb_q[4] ? {pattern_q[0], pattern_q[4:1]}
                                     : {pattern_q[3:0], pattern_q[4]};
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        led_d = '0;
        unique case (state_q)
            StMirror: led_d = deb_q[4:0];
            StToggle: led_d = latch_q;
            StChase:  led_d = pattern_q;
            default:  led_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= '0;
            end
            latch_q    <= '0;
            pattern_q  <= 5'b00001;
            presc_q    <= '0;
            led_q      <= '0;
        end else begin
            sync1_q    <= {mode_btn, sw};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            latch_q    <= latch_d;
            pattern_q  <= pattern_d;
            presc_q    <= presc_d;
            led_q      <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = state_q;

endmodule

// File: tb/tb_button_led_sequencer.sv
// Directed bench: expected led/mode values are queued against absolute clock-edge numbers
// and compared on the falling edge when that edge number is reached.
module tb_button_led_sequencer;

    logic       clk;
    logic       rst;
    logic [4:0] sw;
    logic       mode_btn;
    logic [4:0] led;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        int         cyc;
        logic [4:0] led;
        logic [1:0] mode;
        string      tag;
    } exp_t;

    exp_t sb[$];

    button_led_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .CHASE_DIV      (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .mode_btn(mode_btn),
        .led     (led),
        .mode    (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [4:0] exp_led, input logic [1:0] exp_mode);
        checks++;
        assert (led === exp_led) else begin
            errors++;
            $error("FAIL %s @edge %0d: led=%b expected %b", tag, edge_n, led, exp_led);
        end
        checks++;
        assert (mode === exp_mode) else begin
            errors++;
            $error("FAIL %s @edge %0d: mode=%0d expected %0d", tag, edge_n, mode, exp_mode);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < edge_n) begin
            checks++;
            errors++;
            $error("FAIL stale_%s: edge %0d passed, now at %0d", sb[0].tag, sb[0].cyc, edge_n);
            void'(sb.pop_front());
        end
        while (sb.size() > 0 && sb[0].cyc == edge_n) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, e.led, e.mode);
        end
    end

    task automatic expect_range(input int a, input int b, input logic [4:0] l,
                                input logic [1:0] m, input string tag);
        for (int c = a; c <= b; c++) begin
            sb.push_back('{c, l, m, tag});
        end
    endtask

    task automatic go(input int cyc);
        while (edge_n < cyc) @(negedge clk);
        #2;
    endtask

    // Press and release switches in TOGGLE mode, then expect the resulting latch on led.
    task automatic press(input logic [4:0] bits, input logic [4:0] exp_led, input string tag);
        int n;
        n  = edge_n;
        sw = bits;
        go(n + 6);
        sw = 5'b00000;
        go(n + 14);
        expect_range(edge_n + 1, edge_n + 1, exp_led, 2'd1, tag);
        go(edge_n + 2);
    endtask

    initial begin
        int n, e, t, r;
        rst      = 1'b0;
        sw       = 5'b00000;
        mode_btn = 1'b0;
        #1 rst = 1'b1;
        #2 chk("reset_state", 5'b00000, 2'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Mirror latency: first sampling edge is n+1, led follows on edge n+7.
        n  = edge_n;
        sw = 5'b00101;
        expect_range(n + 1, n + 6, 5'b00000, 2'd0, "mirror_hold");
        expect_range(n + 7, n + 9, 5'b00101, 2'd0, "mirror_led");
        go(n + 10);

        // A 3-cycle glitch on bit1 must be rejected.
        n  = edge_n;
        expect_range(n + 1, n + 14, 5'b00101, 2'd0, "glitch_reject");
        sw = 5'b00111;
        go(n + 3);
        sw = 5'b00101;
        go(n + 16);

        // First mode press: held 20 cycles, single step into TOGGLE, latch cleared.
        n        = edge_n;
        mode_btn = 1'b1;
        expect_range(n + 1, n + 6, 5'b00101, 2'd0, "m1_before");
        expect_range(n + 7, n + 7, 5'b00101, 2'd1, "m1_mode_first");
        expect_range(n + 8, n + 30, 5'b00000, 2'd1, "m1_toggle_clear");
        go(n + 20);
        mode_btn = 1'b0;
        go(n + 22);
        sw = 5'b00000;
        go(n + 32);

        press(5'b00100, 5'b00100, "tog_b2_first");
        press(5'b00100, 5'b00000, "tog_b2_second");
        press(5'b10000, 5'b10000, "tog_b4");

        // Second mode press: chase, then reverse with sw[4], then pause with sw[0].
        n        = edge_n;
        e        = n + 7;
        mode_btn = 1'b1;
        expect_range(n + 1, n + 6, 5'b10000, 2'd1, "m2_before");
        expect_range(e, e, 5'b10000, 2'd2, "m2_mode_first");
        expect_range(e + 1, e + 3, 5'b00001, 2'd2, "chase_l0");
        expect_range(e + 4, e + 6, 5'b00010, 2'd2, "chase_l1");
        expect_range(e + 7, e + 9, 5'b00100, 2'd2, "chase_l2");
        expect_range(e + 10, e + 12, 5'b01000, 2'd2, "chase_l3");
        expect_range(e + 13, e + 15, 5'b10000, 2'd2, "chase_l4");
        expect_range(e + 16, e + 18, 5'b00001, 2'd2, "chase_wrap");
        expect_range(e + 19, e + 21, 5'b00010, 2'd2, "chase_l6");
        expect_range(e + 22, e + 24, 5'b00100, 2'd2, "chase_l7");
        expect_range(e + 25, e + 27, 5'b01000, 2'd2, "chase_l8");
        expect_range(e + 28, e + 30, 5'b00100, 2'd2, "chase_r1");
        expect_range(e + 31, e + 33, 5'b00010, 2'd2, "chase_r2");
        expect_range(e + 34, e + 36, 5'b00001, 2'd2, "chase_r3");
        expect_range(e + 37, e + 39, 5'b10000, 2'd2, "chase_rwrap");
        expect_range(e + 40, e + 42, 5'b01000, 2'd2, "chase_r5");
        expect_range(e + 43, e + 45, 5'b00100, 2'd2, "chase_r6");
        expect_range(e + 46, e + 60, 5'b00010, 2'd2, "chase_pause");
        go(n + 20);
        mode_btn = 1'b0;
        go(e + 19);
        sw = 5'b10000;
        go(e + 40);
        sw = 5'b10001;
        go(e + 61);

        // Third press back to MIRROR shows the debounced switches.
        t        = edge_n;
        mode_btn = 1'b1;
        expect_range(t + 1, t + 6, 5'b00010, 2'd2, "m3_before");
        expect_range(t + 7, t + 7, 5'b00010, 2'd0, "m3_mode_first");
        expect_range(t + 8, t + 20, 5'b10001, 2'd0, "m3_mirror");
        go(t + 20);
        mode_btn = 1'b0;
        go(t + 30);

        // Fourth press: TOGGLE again, the old latch value must not reappear.
        t        = edge_n;
        mode_btn = 1'b1;
        expect_range(t + 1, t + 6, 5'b10001, 2'd0, "m4_before");
        expect_range(t + 7, t + 7, 5'b10001, 2'd1, "m4_mode_first");
        expect_range(t + 8, t + 20, 5'b00000, 2'd1, "m4_latch_cleared");
        go(t + 20);
        mode_btn = 1'b0;
        go(t + 30);

        // Fifth press into CHASE (paused by sw[0]), then an asynchronous reset.
        t        = edge_n;
        mode_btn = 1'b1;
        expect_range(t + 7, t + 7, 5'b00000, 2'd2, "m5_mode_first");
        expect_range(t + 8, t + 20, 5'b00001, 2'd2, "m5_chase_paused");
        go(t + 20);
        mode_btn = 1'b0;
        go(t + 30);

        @(negedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset", 5'b00000, 2'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        r = edge_n;
        expect_range(r + 1, r + 6, 5'b00000, 2'd0, "post_reset_hold");
        expect_range(r + 7, r + 10, 5'b10001, 2'd0, "post_reset_led");
        go(r + 12);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL leftover: %0d expectations unchecked, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
